// File: rtl/ibus_halfword_bridge_pkg.sv
// Shared definitions for the halfword instruction-bus bridge:
// CPU fetch size codes, the bridge state encoding and small size decoders.
package ibus_halfword_bridge_pkg;

    // isiz codes driven by the CPU fetch port
    localparam logic [1:0] ISIZ_IDLE = 2'b00;
    localparam logic [1:0] ISIZ_16   = 2'b01;
    localparam logic [1:0] ISIZ_32   = 2'b10;

    // Bridge sequencing states
    typedef enum logic [1:0] {
        IB_IDLE = 2'b00,
        IB_LO   = 2'b01,
        IB_HI   = 2'b10,
        IB_ACK  = 2'b11
    } ib_state_e;

    // A 16-bit fetch is only the exact 01 code
    function automatic logic is_half(input logic [1:0] siz);
        return siz == ISIZ_16;
    endfunction

    // 11 is treated the same as a 32-bit fetch
    function automatic logic is_word(input logic [1:0] siz);
        return (siz == ISIZ_32) || (siz == 2'b11);
    endfunction

endpackage

// File: rtl/ibus_halfword_bridge_lastword.sv
// Single-entry last-word buffer: remembers the most recent completed 32-bit
// fetch (word tag + data) so an identical re-fetch can skip the memory.
// Flush and fill on the same edge leave the entry invalid.
module ibus_halfword_bridge_lastword #(
    parameter int TAG_W = 22
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             i_flush,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_fill,
    input  logic [TAG_W-1:0] i_fill_tag,
    input  logic [31:0]      i_fill_data,
    output logic             o_hit,
    output logic [31:0]      o_data
);

    logic             r_valid;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_data;

    // Valid bit: flush dominates a simultaneous fill
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
        end
    end

    // Tag and data capture on every completed 32-bit fetch
    // NOTE: tag/data are reset only so outputs are never X; correctness rests on r_valid alone.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_tag  <= '0;
            r_data <= '0;
        end else if (i_fill) begin
            r_tag  <= i_fill_tag;
            r_data <= i_fill_data;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_tag);
    assign o_data = r_data;

endmodule

// File: rtl/ibus_halfword_bridge.sv
// Instruction-bus slave that fetches each 32-bit instruction as two 16-bit
// beats (low halfword at the even word address, high at +2) from a narrow
// memory, and returns the assembled word with a one-cycle iack_o.
// Optional feature macro: IBRIDGE_LASTWORD_EN adds a single-entry last-word
// buffer and the flush_i port; without it every fetch goes to memory.
module ibus_halfword_bridge
    import ibus_halfword_bridge_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [63:0]       iadr_i,
    input  logic [1:0]        isiz_i,
    output logic              iack_o,
    output logic [31:0]       idat_o,
    output logic [ADDR_W-1:0] madr_o,
    output logic              mstb_o,
    input  logic              mack_i,
    input  logic [15:0]       mdat_i
`ifdef IBRIDGE_LASTWORD_EN
    ,
    input  logic              flush_i
`endif
);

    ib_state_e         r_state;
    ib_state_e         w_next_state;
    logic              r_is16;
    logic              r_abandon;
    logic [31:0]       r_idat;
    logic [ADDR_W-1:0] r_madr;

    logic              w_req;
    logic              w_quit;
    logic              w_hit;
    logic [31:0]       w_buf_data;
    logic              w_start;
    logic              w_hit_take;
    logic              w_cap_lo;
    logic              w_cap_hi;
    logic              w_fill;
    logic              w_unused_iadr;

    assign w_req  = (isiz_i != ISIZ_IDLE);
    // Abandon once the CPU drops isiz during a beat; the beat itself still completes
    assign w_quit = r_abandon | ~w_req;

    // Address bits above the memory window and the byte bit are don't-care
    assign w_unused_iadr = ^{iadr_i[63:ADDR_W], iadr_i[0]};

`ifdef IBRIDGE_LASTWORD_EN
    logic w_lw_hit;

    ibus_halfword_bridge_lastword #(
        .TAG_W (ADDR_W - 2)
    ) u_lastword (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .i_flush     (flush_i),
        .i_tag       (iadr_i[ADDR_W-1:2]),
        .i_fill      (w_fill),
        .i_fill_tag  (r_madr[ADDR_W-1:2]),
        .i_fill_data ({mdat_i, r_idat[15:0]}),
        .o_hit       (w_lw_hit),
        .o_data      (w_buf_data)
    );

    // Only 32-bit requests can hit; a flush on the same edge forces a memory fetch
    assign w_hit = w_lw_hit && is_word(isiz_i) && !flush_i;
`else
    assign w_hit      = 1'b0;
    assign w_buf_data = '0;
`endif

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-edge datapath controls
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_hit_take   = 1'b0;
        w_cap_lo     = 1'b0;
        w_cap_hi     = 1'b0;
        w_fill       = 1'b0;
        case (r_state)
            IB_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        w_next_state = IB_ACK;
                        w_hit_take   = 1'b1;
                    end else begin
                        w_next_state = IB_LO;
                        w_start      = 1'b1;
                    end
                end
            end
            IB_LO: begin
                if (mack_i) begin
                    w_cap_lo = 1'b1;
                    if (w_quit) begin
                        w_next_state = IB_IDLE;
                    end else if (r_is16) begin
                        w_next_state = IB_ACK;
                    end else begin
                        w_next_state = IB_HI;
                    end
                end
            end
            IB_HI: begin
                if (mack_i) begin
                    w_cap_hi = 1'b1;
                    if (w_quit) begin
                        w_next_state = IB_IDLE;
                    end else begin
                        w_next_state = IB_ACK;
                        w_fill       = 1'b1;
                    end
                end
            end
            IB_ACK: begin
                // isiz still held by the CPU here is the same request, not a new one
                w_next_state = IB_IDLE;
            end
            default: begin
                w_next_state = IB_IDLE;
            end
        endcase
    end

    // Request latch, halfword address stepping and read-data assembly
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_madr <= '0;
            r_is16 <= 1'b0;
            r_idat <= '0;
        end else begin
            if (w_start) begin
                // Word fetches start at the even word address; halfword fetches keep bit 1
                r_madr <= {iadr_i[ADDR_W-1:2], iadr_i[1] & is_half(isiz_i), 1'b0};
                r_is16 <= is_half(isiz_i);
            end else if (w_cap_lo && (w_next_state == IB_HI)) begin
                r_madr <= r_madr + ADDR_W'(2);
            end
            if (w_hit_take) begin
                r_idat <= w_buf_data;
            end else if (w_cap_lo) begin
                r_idat <= {16'h0000, mdat_i};
            end else if (w_cap_hi) begin
                r_idat[31:16] <= mdat_i;
            end
        end
    end

    // Sticky abandon flag: set if isiz is seen idle while a beat is outstanding
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_abandon <= 1'b0;
        end else if (w_start) begin
            r_abandon <= 1'b0;
        end else if (((r_state == IB_LO) || (r_state == IB_HI)) && !w_req) begin
            r_abandon <= 1'b1;
        end
    end

    // Strobe and acknowledge decode straight from the state, so reset drops them at once
    assign mstb_o = (r_state == IB_LO) || (r_state == IB_HI);
    assign iack_o = (r_state == IB_ACK);
    assign madr_o = r_madr;
    assign idat_o = r_idat;

endmodule

// File: tb/tb_ibus_halfword_bridge.sv
// Self-checking bench for ibus_halfword_bridge: directed corner cases plus
// randomized fetches checked against an address-level memory and latency model.
// Build with IBRIDGE_LASTWORD_EN defined to also exercise the last-word buffer.
module tb_ibus_halfword_bridge;

    localparam int AW = 24;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [63:0]   iadr_i;
    logic [1:0]    isiz_i;
    logic          iack_o;
    logic [31:0]   idat_o;
    logic [AW-1:0] madr_o;
    logic          mstb_o;
    logic          mack_i;
    logic [15:0]   mdat_i;
`ifdef IBRIDGE_LASTWORD_EN
    logic          flush_i;
`endif

    int n_vec = 0;
    int n_err = 0;

    int            cfg_waits = 0;
    int            wcnt = 0;
    logic [AW-1:0] beat_q[$];
    logic [15:0]   mem_ovr[logic [AW-1:0]];

    // Reference state of the last-word buffer
    bit            lw_valid = 1'b0;
    logic [AW-3:0] lw_tag = '0;

    ibus_halfword_bridge #(.ADDR_W(AW)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .iadr_i  (iadr_i),
        .isiz_i  (isiz_i),
        .iack_o  (iack_o),
        .idat_o  (idat_o),
        .madr_o  (madr_o),
        .mstb_o  (mstb_o),
        .mack_i  (mack_i),
        .mdat_i  (mdat_i)
`ifdef IBRIDGE_LASTWORD_EN
        ,
        .flush_i (flush_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] mem_rd(input logic [AW-1:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return a[15:0] ^ {a[23:16], 8'hA5};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: cfg_waits low cycles of mack per beat, then one ack cycle
    always @(negedge clk_i) begin
        if (mstb_o === 1'b1) begin
            if (wcnt < cfg_waits) begin
                mack_i = 1'b0;
                wcnt++;
            end else begin
                mack_i = 1'b1;
                mdat_i = mem_rd(madr_o);
                beat_q.push_back(madr_o);
                wcnt = 0;
            end
        end else begin
            mack_i = 1'b0;
            wcnt = 0;
        end
    end

    // One CPU fetch: hold isiz through the ACK edge, then one idle cycle
    task automatic do_fetch(input logic [63:0] adr, input logic [1:0] siz, input int waits);
        logic [AW-1:0] a;
        logic [AW-1:0] exp_beats[$];
        logic [31:0]   exp_w;
        bit            is16;
        bit            hit;
        int            exp_lat;
        int            lat;
        a    = adr[AW-1:0];
        is16 = (siz == 2'b01);
        if (is16) begin
            a[0]  = 1'b0;
            exp_w = {16'h0000, mem_rd(a)};
            exp_beats.push_back(a);
        end else begin
            a[1:0] = 2'b00;
            exp_w  = {mem_rd(a + 24'd2), mem_rd(a)};
            exp_beats.push_back(a);
            exp_beats.push_back(a + 24'd2);
        end
        hit = 1'b0;
`ifdef IBRIDGE_LASTWORD_EN
        hit = !is16 && lw_valid && (lw_tag == a[AW-1:2]);
        if (hit) exp_beats.delete();
`endif
        exp_lat = hit ? 1 : 1 + exp_beats.size() * (1 + waits);
        cfg_waits = waits;
        beat_q.delete();
        iadr_i = adr;
        isiz_i = siz;
        @(posedge clk_i); #1;
        // The latched address must be used, whatever the CPU drives afterwards
        iadr_i = {$urandom, $urandom};
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            if (iack_o) begin
                lat = c;
                break;
            end
            @(posedge clk_i); #1;
        end
        check("ack_latency", lat, exp_lat);
        if (lat != 0) begin
            check("idat", idat_o, exp_w);
            check("mstb_at_ack", mstb_o, 1'b0);
            @(posedge clk_i); #1;
            check("single_pulse", iack_o, 1'b0);
        end
        isiz_i = 2'b00;
        @(posedge clk_i); #1;
        check("beat_count", beat_q.size(), exp_beats.size());
        for (int i = 0; i < exp_beats.size() && i < beat_q.size(); i++) begin
            check("beat_addr", beat_q[i], exp_beats[i]);
        end
        if (!is16 && !hit) begin
            lw_valid = 1'b1;
            lw_tag   = a[AW-1:2];
        end
    endtask

`ifdef IBRIDGE_LASTWORD_EN
    task automatic pulse_flush();
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        lw_valid = 1'b0;
    endtask
`endif

    initial begin
        logic [63:0] adr;
        logic [63:0] prev;
        logic [1:0]  siz;
        bit          seen;
        reset_i = 1'b0;
        iadr_i  = '0;
        isiz_i  = 2'b00;
        mack_i  = 1'b0;
        mdat_i  = '0;
`ifdef IBRIDGE_LASTWORD_EN
        flush_i = 1'b0;
`endif
        #2;
        check("rst_iack", iack_o, 1'b0);
        check("rst_mstb", mstb_o, 1'b0);
        check("rst_madr", madr_o, '0);
        check("rst_idat", idat_o, '0);
        @(posedge clk_i); @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(posedge clk_i); #1;

        // Reset-vector fetch with wrap of the upper address bits
        mem_ovr[24'hFFFF00] = 16'h0013;
        mem_ovr[24'hFFFF02] = 16'h0000;
        do_fetch(64'hFFFF_FFFF_FFFF_FF00, 2'b10, 0);

        // Two wait cycles per beat
        mem_ovr[24'h000124] = 16'h0113;
        mem_ovr[24'h000126] = 16'h1240;
        do_fetch(64'h124, 2'b10, 2);

        // Single-beat halfword fetch
        mem_ovr[24'h000126] = 16'hABCD;
        do_fetch(64'h126, 2'b01, 0);

        // Back-to-back requests to the same word (hit when the buffer exists)
        do_fetch(64'h4000, 2'b11, 0);
        do_fetch(64'h4000, 2'b10, 1);
`ifdef IBRIDGE_LASTWORD_EN
        pulse_flush();
        do_fetch(64'h4000, 2'b10, 0);
`endif

        // Abandon during the low beat
        cfg_waits = 1;
        beat_q.delete();
        iadr_i = 64'h800;
        isiz_i = 2'b10;
        @(posedge clk_i); #1;
        isiz_i = 2'b00;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk_i); #1;
            if (iack_o) seen = 1'b1;
        end
        check("abandon_noack", seen, 1'b0);
        check("abandon_mstb", mstb_o, 1'b0);
        check("abandon_beats", beat_q.size(), 1);
        if (beat_q.size() > 0) check("abandon_addr", beat_q[0], 24'h000800);
        do_fetch(64'h900, 2'b10, 0);

        // Asynchronous reset in the middle of the low beat
        cfg_waits = 3;
        iadr_i = 64'h2000;
        isiz_i = 2'b10;
        @(posedge clk_i); #1;
        check("lo_mstb", mstb_o, 1'b1);
        #2;
        reset_i = 1'b0;
        #1;
        check("midrst_iack", iack_o, 1'b0);
        check("midrst_mstb", mstb_o, 1'b0);
        check("midrst_madr", madr_o, '0);
        check("midrst_idat", idat_o, '0);
        isiz_i = 2'b00;
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        lw_valid = 1'b0;
        @(posedge clk_i); #1;
        do_fetch(64'h900, 2'b10, 0);

        // Randomized fetches, sometimes repeating the previous address
        prev = 64'h900;
        for (int n = 0; n < 40; n++) begin
            adr = {$urandom, $urandom};
            if (($urandom % 4) == 0) adr = prev;
            case ($urandom % 3)
                0:       siz = 2'b01;
                1:       siz = 2'b10;
                default: siz = 2'b11;
            endcase
`ifdef IBRIDGE_LASTWORD_EN
            if (($urandom % 5) == 0) pulse_flush();
`endif
            do_fetch(adr, siz, int'($urandom_range(0, 2)));
            prev = adr;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
